rv32i_mem_arbiter: RTL
======================

Name: rv32i_mem_arbiter

Overview:
Shares the single memory port (async read, sync write) between the rv32i multicycle core and a secondary debug/loader master. The block drives the core's ena to stall it when the debug master must preempt the port, and provides a lock mode for bulk program loading.
- Integration requirement: every core state element, including the register-file write enable, is qualified by ena. A stalled core is therefore fully frozen.

Parameters:
STARVE_LIMIT, 4, cycles a pending debug request waits behind core memory cycles before it preempts the core (range 1..255).
CNT_W, $clog2(STARVE_LIMIT+1), width of the wait counter (derived; not overridden).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ena_in  in  1  global run enable for the core
core_ena  out  1  ena to core
core_mem_req  in  1  core is in a memory state (fetch/load/store) this cycle
core_mem_addr  in  32  core address
core_mem_wr_data  in  32  core write data
core_mem_wr_ena  in  1  core write strobe
core_mem_rd_data  out  32  read data to core (= mem_rd_data)
dbg_req  in  1  debug access request; addr/data/wr held stable until granted
dbg_lock  in  1  request exclusive bus ownership
dbg_addr  in  32  debug address
dbg_wr_ena  in  1  1=write, 0=read
dbg_wr_data  in  32  debug write data
dbg_gnt  out  1  access performed this cycle (combinational)
dbg_rd_data  out  32  registered read data
dbg_rd_valid  out  1  one-cycle pulse, cycle after a granted read
dbg_locked  out  1  arbiter is in ARB_LOCK
stall_count  out  32  saturating count of cycles the core was stalled by the arbiter
mem_addr  out  32  memory address
mem_wr_data  out  32  memory write data
mem_wr_ena  out  1  memory write strobe
mem_rd_data  in  32  memory read data

Behaviour:
- Reset: state ARB_CORE, wait_cnt 0, dbg_rd_valid 0, dbg_rd_data 0, stall_count 0.
- While rst=1, outputs are forced: core_ena=0, dbg_gnt=0, mem_wr_ena=0, mem_addr=0, mem_wr_data=0.
- Owner mux: when dbg_gnt=1, mem_* come from dbg_*; otherwise they come from core_*.
- mem_wr_ena is never asserted for the non-owner.
- State ARB_CORE:
  - dbg_req & (~core_mem_req | ~ena_in): dbg_gnt=1; core_ena=ena_in (no stall); wait_cnt<=0.
  - dbg_req & core_mem_req & ena_in & wait_cnt<STARVE_LIMIT: dbg_gnt=0; core owns the bus; wait_cnt<=wait_cnt+1.
  - dbg_req & core_mem_req & ena_in & wait_cnt==STARVE_LIMIT: dbg_gnt=1; core_ena=0 (stall one cycle); stall_count++; wait_cnt<=0.
  - ~dbg_req: core_ena=ena_in; wait_cnt<=0.
  - dbg_lock=1: next state ARB_LOCK. The current cycle is still arbitrated as above.
- State ARB_LOCK:
  - core_ena=0 every cycle; dbg_gnt=dbg_req; bus owned by dbg.
  - stall_count increments every cycle while ena_in=1.
  - dbg_lock=0: next state ARB_CORE; wait_cnt<=0.
- Read return: on a granted read (dbg_gnt & ~dbg_wr_ena), dbg_rd_data<=mem_rd_data and dbg_rd_valid<=1 at the next edge; otherwise dbg_rd_valid<=0. Back-to-back grants give back-to-back valid pulses.
- A debug write is performed at the granted edge; there is no response pulse.
- core_mem_rd_data = mem_rd_data always. During a stall cycle the core ignores it because ena=0.
- stall_count saturates at 32'hFFFF_FFFF.
- dbg_locked = (state==ARB_LOCK).
- Reset mid-lock: returns to ARB_CORE immediately. A pending dbg request is dropped and the master must re-request.
- Simultaneous dbg_req and dbg_lock entry: the request is arbitrated normally this cycle; lock takes effect the next cycle.
- Illegal/unknown state: next state ARB_CORE.

Decomposition:
- Shared package (rv32i_defines): arb_state_t enum {ARB_CORE, ARB_LOCK}.
- Single module. The saturating stall counter stays inline, with no sub-module.

Test Plan:
- Idle core (core_mem_req=0), dbg read addr 0x40 with mem returning 0xDEADBEEF -> dbg_gnt=1 same cycle; core_ena=1; next cycle dbg_rd_valid=1, dbg_rd_data=0xDEADBEEF; stall_count=0.
- core_mem_req held 1, dbg write pending, STARVE_LIMIT=4 -> gnt=0 for 4 cycles; 5th cycle gnt=1, core_ena=0, mem_wr_ena=1, mem_addr=dbg_addr; stall_count=1.
- dbg_lock=1, then 16 sequential writes to 0x0..0x3C -> dbg_locked=1 from next cycle; core_ena=0 throughout; all 16 writes land; drop lock -> core_ena=1 next cycle.
- Core store (core_mem_wr_ena=1) with no dbg_req -> mem_wr_ena=1, mem_addr=core_mem_addr, dbg_gnt=0.
- ena_in=0 with core_mem_req=1 and dbg read -> immediate grant; core_ena=0; stall_count unchanged.
- rst asserted during ARB_LOCK with dbg_req=1 -> next cycle state ARB_CORE, dbg_rd_valid=0, stall_count=0, wait_cnt=0.

Source files
------------

// File: rtl/rv32i_defines.sv
// Shared definitions for the rv32i memory arbiter.
package rv32i_defines;

  typedef enum logic [0:0] {
    ARB_CORE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rv32i_mem_arbiter.sv
// Shares the single memory port between the rv32i core and a debug/loader master.
// The debug master preempts the core by dropping core_ena, or holds the port via lock.
module rv32i_mem_arbiter
  import rv32i_defines::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena_in,
  output logic        core_ena,
  input  logic        core_mem_req,
  input  logic [31:0] core_mem_addr,
  input  logic [31:0] core_mem_wr_data,
  input  logic        core_mem_wr_ena,
  output logic [31:0] core_mem_rd_data,
  input  logic        dbg_req,
  input  logic        dbg_lock,
  input  logic [31:0] dbg_addr,
  input  logic        dbg_wr_ena,
  input  logic [31:0] dbg_wr_data,
  output logic        dbg_gnt,
  output logic [31:0] dbg_rd_data,
  output logic        dbg_rd_valid,
  output logic        dbg_locked,
  output logic [31:0] stall_count,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_ena,
  input  logic [31:0] mem_rd_data
);

  arb_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_nxt;
  logic [31:0]      r_stall_cnt;
  logic [31:0]      r_rd_data;
  logic             r_rd_valid;
  logic             w_gnt;
  logic             w_core_ena;
  logic             w_stall_inc;
  logic             w_dbg_own;

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_gnt       = 1'b0;
    w_core_ena  = ena_in;
    w_stall_inc = 1'b0;
    unique case (r_state)
      ARB_CORE: begin
        if (dbg_req) begin
          if (!core_mem_req || !ena_in) begin
            w_gnt      = 1'b1;
            w_wait_nxt = '0;
          end else if (r_wait_cnt < CNT_W'(STARVE_LIMIT)) begin
            w_wait_nxt = r_wait_cnt + 1'b1;
          end else begin
            // Starvation limit reached: freeze the core for one cycle and take the port.
            w_gnt       = 1'b1;
            w_core_ena  = 1'b0;
            w_stall_inc = 1'b1;
            w_wait_nxt  = '0;
          end
        end else begin
          w_wait_nxt = '0;
        end
        if (dbg_lock) w_state_nxt = ARB_LOCK;
      end
      ARB_LOCK: begin
        w_core_ena  = 1'b0;
        w_gnt       = dbg_req;
        w_stall_inc = ena_in;
        if (!dbg_lock) begin
          w_state_nxt = ARB_CORE;
          w_wait_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ARB_CORE;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // In lock the debug master owns the port even between requests.
  assign w_dbg_own = w_gnt || (r_state == ARB_LOCK);

  always_comb begin
    core_ena    = 1'b0;
    dbg_gnt     = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_ena  = 1'b0;
    if (!rst) begin
      core_ena = w_core_ena;
      dbg_gnt  = w_gnt;
      if (w_dbg_own) begin
        mem_addr    = dbg_addr;
        mem_wr_data = dbg_wr_data;
        mem_wr_ena  = w_gnt & dbg_wr_ena;
      end else begin
        mem_addr    = core_mem_addr;
        mem_wr_data = core_mem_wr_data;
        mem_wr_ena  = core_mem_wr_ena;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_CORE;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_stall_inc && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      r_rd_valid <= w_gnt & ~dbg_wr_ena;
      if (w_gnt && !dbg_wr_ena) r_rd_data <= mem_rd_data;
    end
  end

  assign core_mem_rd_data = mem_rd_data;
  assign dbg_rd_data      = r_rd_data;
  assign dbg_rd_valid     = r_rd_valid;
  assign dbg_locked       = (r_state == ARB_LOCK);
  assign stall_count      = r_stall_cnt;

endmodule
